// File: rtl/instr_fetch.sv
// instr_fetch: upstream stage of the multi-cycle CPU datapath.
// Drives the PC into an asynchronous-read instruction ROM, captures each
// returned word with its PC in a 2-entry prefetch queue, and hands the queue
// head to decode through a valid/ready handshake. A redirect (branch or
// exception return) reloads the PC and flushes the queue.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   fetch_en   in   allow new fetches (queue keeps draining when low)
//   mem_addr   out  ROM word address (= PC)
//   mem_rdata  in   ROM data for mem_addr, same cycle
//   br_valid   in   redirect pulse
//   br_target  in   redirect target PC
//   IR         out  instruction at queue head
//   ir_pc      out  PC of instruction at queue head
//   ir_valid   out  head is live (combinational)
//   ir_ready   in   consumer accepts head this cycle
//   q_count    out  queue occupancy 0..2
module instr_fetch #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [1:0]        q_count
);

    localparam int unsigned DEPTH = 2;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0] epc_q   [DEPTH];
    logic [ADDR_W-1:0] epc_d   [DEPTH];

    logic push_c;
    logic pop_c;

    // Handshake and queue events; a redirect suppresses both.
    assign ir_valid = (count_q != 2'd0) && !br_valid;
    assign pop_c    = ir_valid && ir_ready;
    assign push_c   = fetch_en && !br_valid && ((count_q < 2'd2) || pop_c);

    assign mem_addr = pc_q;
    assign IR       = instr_q[rd_ptr_q];
    assign ir_pc    = epc_q[rd_ptr_q];
    assign q_count  = count_q;

    // Next-state logic: redirect flush, otherwise push/pop bookkeeping.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        epc_d    = epc_q;

        if (br_valid) begin
            pc_d     = br_target;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            // A push into a full queue overwrites the head being popped,
            // which is safe because the head is read combinationally.
            if (push_c) begin
                instr_d[wr_ptr_q] = mem_rdata;
                epc_d[wr_ptr_q]   = pc_q;
                wr_ptr_d          = ~wr_ptr_q;
                pc_d              = pc_q + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset overrides redirect and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            instr_q  <= '{default: '0};
            epc_q    <= '{default: '0};
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            epc_q    <= epc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational ROM
// model: ROM[i] = 0xE000_0000 + i.
module tb_instr_fetch;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] ROM_BASE = 32'hE000_0000;

    logic              clk;
    logic              rst;
    logic              fetch_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic [DATA_W-1:0] IR;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [1:0]        q_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .br_valid  (br_valid),
        .br_target (br_target),
        .IR        (IR),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .q_count   (q_count)
    );

    assign mem_rdata = ROM_BASE + 32'(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        fetch_en  = 1'b0;
        ir_ready  = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        step();
        step();

        // Reset state
        check_eq("rst_count", 32'(q_count), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_ir", IR, 32'd0);
        check_eq("rst_irpc", 32'(ir_pc), 32'd0);
        check_eq("rst_valid", 32'(ir_valid), 32'd0);

        // Release reset and stream
        rst      = 1'b0;
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        #1;
        check_eq("rel_valid_low", 32'(ir_valid), 32'd0);
        step();
        check_eq("rel_valid_high", 32'(ir_valid), 32'd1);
        check_eq("stream_ir0", IR, ROM_BASE);
        check_eq("stream_pc0", 32'(ir_pc), 32'd0);
        check_eq("stream_cnt0", 32'(q_count), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq("stream_ir", IR, ROM_BASE + 32'(k));
            check_eq("stream_pc", 32'(ir_pc), 32'(k));
            check_eq("stream_cnt", 32'(q_count), 32'd1);
        end

        // Back-pressure: head 5 held, queue fills, PC stops at 7
        ir_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("bp_ir", IR, ROM_BASE + 32'd5);
            check_eq("bp_pc", 32'(ir_pc), 32'd5);
            check_eq("bp_valid", 32'(ir_valid), 32'd1);
            check_eq("bp_cnt", 32'(q_count), 32'd2);
            check_eq("bp_addr", 32'(mem_addr), 32'd7);
        end
        ir_ready = 1'b1;
        for (int k = 6; k <= 8; k++) begin
            step();
            check_eq("resume_ir", IR, ROM_BASE + 32'(k));
            check_eq("resume_pc", 32'(ir_pc), 32'(k));
            check_eq("resume_cnt", 32'(q_count), 32'd2);
        end

        // Redirect with a full queue
        br_valid  = 1'b1;
        br_target = 6'h20;
        #1;
        check_eq("br_valid_low", 32'(ir_valid), 32'd0);
        check_eq("br_head_ir", IR, ROM_BASE + 32'd8);
        step();
        br_valid = 1'b0;
        #1;
        check_eq("br_cnt", 32'(q_count), 32'd0);
        check_eq("br_addr", 32'(mem_addr), 32'h20);
        check_eq("br_valid_gap", 32'(ir_valid), 32'd0);
        step();
        check_eq("br_ir", IR, ROM_BASE + 32'h20);
        check_eq("br_irpc", 32'(ir_pc), 32'h20);
        check_eq("br_valid_up", 32'(ir_valid), 32'd1);

        // PC wrap
        br_valid  = 1'b1;
        br_target = 6'h3E;
        step();
        br_valid = 1'b0;
        step();
        check_eq("wrap_pc0", 32'(ir_pc), 32'h3E);
        step();
        check_eq("wrap_pc1", 32'(ir_pc), 32'h3F);
        step();
        check_eq("wrap_pc2", 32'(ir_pc), 32'h00);
        check_eq("wrap_ir2", IR, ROM_BASE);
        step();
        check_eq("wrap_pc3", 32'(ir_pc), 32'h01);

        // fetch_en gating: fill to 2 (heads 1,2), then drain with fetch off
        ir_ready = 1'b0;
        step();
        check_eq("gate_fill", 32'(q_count), 32'd2);
        check_eq("gate_fill_addr", 32'(mem_addr), 32'd3);
        fetch_en = 1'b0;
        ir_ready = 1'b1;
        step();
        check_eq("gate_d1_pc", 32'(ir_pc), 32'd2);
        check_eq("gate_d1_valid", 32'(ir_valid), 32'd1);
        check_eq("gate_d1_cnt", 32'(q_count), 32'd1);
        step();
        check_eq("gate_empty_valid", 32'(ir_valid), 32'd0);
        check_eq("gate_empty_cnt", 32'(q_count), 32'd0);
        step();
        check_eq("gate_hold_addr", 32'(mem_addr), 32'd3);
        check_eq("gate_hold_valid", 32'(ir_valid), 32'd0);
        fetch_en = 1'b1;
        step();
        check_eq("gate_resume_pc", 32'(ir_pc), 32'd3);
        check_eq("gate_resume_ir", IR, ROM_BASE + 32'd3);
        step();
        check_eq("gate_resume_pc2", 32'(ir_pc), 32'd4);

        // Reset mid-operation with full queue, ready and redirect asserted
        ir_ready = 1'b0;
        step();
        check_eq("mid_full", 32'(q_count), 32'd2);
        rst       = 1'b1;
        ir_ready  = 1'b1;
        br_valid  = 1'b1;
        br_target = 6'h10;
        step();
        rst      = 1'b0;
        br_valid = 1'b0;
        fetch_en = 1'b0;
        #1;
        check_eq("mid_rst_cnt", 32'(q_count), 32'd0);
        check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
        check_eq("mid_rst_ir", IR, 32'd0);
        check_eq("mid_rst_valid", 32'(ir_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
